// File: rtl/led_pkg.sv
// Shared constants for LED / display blocks: blink FSM state encoding and
// counter sizing helper.
package led_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_ON   = 2'd1;
  localparam logic [ST_W-1:0] ST_OFF  = 2'd2;

  // Width of a counter that must reach max(a,b)-1; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_rise_detect.sv
// Registered copy of an input plus a one-cycle pulse on each rising edge.
// The pulse is combinational from i_Sig; consumers are expected to register it.
module rise_detect
  import led_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Sig,
  output logic o_Rise
);

  logic r_Sig;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_Sig <= 1'b0;
    else       r_Sig <= i_Sig;
  end

  assign o_Rise = i_Sig & ~r_Sig;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle event rises into visible LED blinks (ON_CYCLES lit,
// OFF_CYCLES dark), queueing up to PEND_MAX events that arrive mid-blink.
module led_pulse_stretcher
  import led_pkg::*;
#(
  parameter int ON_CYCLES  = 250000,
  parameter int OFF_CYCLES = 250000,
  parameter int PEND_MAX   = 3
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Event,
  output logic o_LED,
  output logic o_Busy,
  output logic o_Overflow
);

  localparam int CW = cnt_width(ON_CYCLES, OFF_CYCLES);
  localparam int PW = $clog2(PEND_MAX + 1);

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  logic [ST_W-1:0] r_State;
  logic [CW-1:0]   r_Cnt;
  logic [PW-1:0]   r_Pend;
  logic            r_LED;
  logic            r_Ovf;

  logic w_Rise;
  logic w_OnTerm, w_OffTerm;
  logic w_Start, w_Deq, w_Queue, w_Full;

  rise_detect u_rise (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Sig  (i_Event),
    .o_Rise (w_Rise)
  );

  assign w_OnTerm  = (r_State == ST_ON)  && (r_Cnt == ON_LAST);
  assign w_OffTerm = (r_State == ST_OFF) && (r_Cnt == OFF_LAST);
  assign w_Full    = (r_Pend == PEND_FULL);

  // A new blink starts from IDLE on a rise, or back-to-back at the end of a
  // gap when something is queued or a rise lands exactly on the last dark cycle.
  assign w_Start = ((r_State == ST_IDLE) & w_Rise)
                 | (w_OffTerm & (w_Rise | (r_Pend != '0)));
  assign w_Deq   = w_OffTerm & (r_Pend != '0);
  assign w_Queue = w_Rise & ((r_State == ST_ON) | ((r_State == ST_OFF) & ~w_OffTerm));

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= ST_IDLE;
      r_Cnt   <= '0;
      r_LED   <= 1'b0;
    end else if (w_Start) begin
      r_State <= ST_ON;
      r_Cnt   <= '0;
      r_LED   <= 1'b1;
    end else if (w_OnTerm) begin
      r_State <= ST_OFF;
      r_Cnt   <= '0;
      r_LED   <= 1'b0;
    end else if (w_OffTerm) begin
      r_State <= ST_IDLE;
      r_Cnt   <= '0;
    end else if (r_State == ST_ON || r_State == ST_OFF) begin
      r_Cnt <= r_Cnt + CW'(1);
    end else begin
      r_State <= ST_IDLE;
      r_Cnt   <= '0;
      r_LED   <= 1'b0;
    end
  end

  // A rise on the last dark cycle with a non-empty queue replaces the entry
  // being dequeued, so the count holds and no overflow is raised.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Pend <= '0;
      r_Ovf  <= 1'b0;
    end else begin
      r_Ovf <= w_Queue & w_Full;
      if (w_Deq & ~w_Rise)
        r_Pend <= r_Pend - PW'(1);
      else if (w_Queue & ~w_Full)
        r_Pend <= r_Pend + PW'(1);
    end
  end

  assign o_LED      = r_LED;
  assign o_Overflow = r_Ovf;
  assign o_Busy     = (r_State != ST_IDLE) | (r_Pend != '0);

endmodule
